// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
// It produces one quotient bit per cycle and returns {remainder, quotient}.
// Optional feature macro: DIV_ZERO_FAST_EN. When defined, a zero divisor
// skips the iterations and returns 0 after a single BYZERO cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned WRKW = 2 * W + 1;

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_END = 2'd2, S_BYZERO = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_END = 2'd2} state_t;
`endif

  state_t          state, state_nxt;
  logic [WRKW-1:0] work, work_nxt;
  logic [W-1:0]    divisor, divisor_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            neg_q, neg_q_nxt;
  logic            neg_r, neg_r_nxt;
  logic            ready_nxt;
  logic [2*W-1:0]  result_nxt;

  logic [W-1:0]    abs1, abs2;
  logic [WRKW:0]   shifted;
  logic [W+1:0]    diff;
  logic [W-1:0]    quot, rem;

  // Operand magnitudes, one shift/subtract step, and the sign fix-up terms.
  always_comb begin
    abs1    = (signed_div && opdata1[W-1]) ? (~opdata1 + 32'd1) : opdata1;
    abs2    = (signed_div && opdata2[W-1]) ? (~opdata2 + 32'd1) : opdata2;
    shifted = {work, 1'b0};
    diff    = shifted[WRKW:W] - {2'b00, divisor};
    quot    = work[W-1:0];
    rem     = work[2*W-1:W];
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      work    <= '0;
      divisor <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      divisor <= divisor_nxt;
      cnt     <= cnt_nxt;
      neg_q   <= neg_q_nxt;
      neg_r   <= neg_r_nxt;
      ready   <= ready_nxt;
      result  <= result_nxt;
    end
  end

  // Next-state selection. A flush always wins.
  always_comb begin
    state_nxt = state;
    if (annul) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            state_nxt = (opdata2 == '0) ? S_BYZERO : S_ON;
`else
            state_nxt = S_ON;
`endif
          end
        end
`ifdef DIV_ZERO_FAST_EN
        S_BYZERO: state_nxt = S_END;
`endif
        S_ON:     if (cnt == CW'(W)) state_nxt = S_END;
        S_END:    if (!start) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath updates and next values of the registered outputs.
  always_comb begin
    work_nxt    = work;
    divisor_nxt = divisor;
    cnt_nxt     = cnt;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    ready_nxt   = ready;
    result_nxt  = result;
    if (annul) begin
      ready_nxt  = 1'b0;
      result_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_nxt  = 1'b0;
          result_nxt = '0;
          if (start) begin
            work_nxt    = {{(W+1){1'b0}}, abs1};
            divisor_nxt = abs2;
            cnt_nxt     = '0;
            neg_q_nxt   = signed_div && (opdata1[W-1] ^ opdata2[W-1]);
            neg_r_nxt   = signed_div && opdata1[W-1];
          end
        end
`ifdef DIV_ZERO_FAST_EN
        S_BYZERO: begin
          ready_nxt  = 1'b1;
          result_nxt = '0;
        end
`endif
        S_ON: begin
          if (cnt == CW'(W)) begin
            ready_nxt  = 1'b1;
            result_nxt = {(neg_r ? (~rem + 32'd1) : rem),
                          (neg_q ? (~quot + 32'd1) : quot)};
          end else begin
            // Keep the difference when non-negative, otherwise restore.
            if (!diff[W+1]) begin
              work_nxt = {diff[W:0], shifted[W-1:1], 1'b1};
            end else begin
              work_nxt = shifted[WRKW-1:0];
            end
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_END: begin
          if (!start) begin
            ready_nxt  = 1'b0;
            result_nxt = '0;
          end
        end
        default: begin
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int tests = 0;
  int fails = 0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide, measure latency from the capture edge, check the
  // result, hold start for one more cycle, then release it.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp, input int exp_lat,
                         input bit scramble);
    int n;
    bit got;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (ready) got = 1;
      else if (scramble) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      end
    end
    check({tag, "_lat"}, 64'(n - 1), 64'(exp_lat));
    check({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_hold"}, {ready, result}, {1'b1, exp});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop"}, {ready, result}, 65'h0);
  endtask

  // Watch for a spurious ready over a window of cycles.
  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int bound;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {ready, result}, 65'h0);
    @(negedge clk);
    rst = 1'b0;

    run_div("divu_7_2",     32'd7,          32'd2,          1'b0, 64'h00000001_00000003, 33, 0);
    run_div("div_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_div("div_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33, 0);
    run_div("div_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33, 0);
    run_div("divu_max_1",   32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF, 33, 0);
    run_div("div_m100_m7",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 64'hFFFFFFFE_0000000E, 33, 0);
    run_div("divu_scram",   32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33, 1);
    run_div("div_scram",    32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1);
`ifdef DIV_ZERO_FAST_EN
    run_div("divu_zero",    32'd5,          32'd0,          1'b0, 64'h0, 1, 0);
`else
    run_div("divu_zero",    32'd5,          32'd0,          1'b0, 64'h00000005_FFFFFFFF, 33, 0);
`endif

    // Flush at iteration 10.
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_on", {ready, result}, 65'h0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    quiet("annul_on_quiet", 40);

    // Reset at iteration 20 of a second divide.
    @(negedge clk);
    start = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rst_on", {ready, result}, 65'h0);
    @(negedge clk);
    rst = 1'b0;
    quiet("rst_on_quiet", 40);

    // Flush in END with start held; flush must also block start in IDLE.
    @(negedge clk);
    opdata1 = 32'd9; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    bound = 0;
    while (!ready && bound < 80) begin
      @(posedge clk); #1;
      bound++;
    end
    check("annul_end_reach", {ready, result}, {1'b1, 64'h00000000_00000003});
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_end", {ready, result}, 65'h0);
    @(posedge clk); #1;
    check("annul_idle", {ready, result}, 65'h0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    quiet("annul_idle_quiet", 40);

    run_div("fresh", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving DIV/DIVU in the execute stage. Accepts a start request from the execute-stage control, iterates one quotient bit per cycle, then presents a 64-bit {remainder, quotient} result with a ready flag. The ALU holds the pipeline (`stall_div`) until ready propagates to the memory stage, then writes the result into HI/LO. HI = remainder, LO = quotient.

## Interface
- No parameters; operand width is fixed at 32.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: division requested; held high by execute stage until `ready` is consumed.
- `signed_div` input 1: 1 = DIV (two's complement), 0 = DIVU; sampled with `start` in IDLE.
- `opdata1` input 32: dividend (rs); sampled with `start` in IDLE.
- `opdata2` input 32: divisor (rt); sampled with `start` in IDLE.
- `annul` input 1: flush; abort any operation.
- `result` output 64: {remainder[31:0], quotient[31:0]}; valid while `ready`=1.
- `ready` output 1: result valid.

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE: `ready`=0, `result`=0. If `start`=1 and `annul`=0: latch operands and `signed_div`; go ON (or BYZERO, see Configuration). When `signed_div`=1, latch |opdata1| and |opdata2|, and record sign flags: quotient negative = sign1 XOR sign2; remainder negative = sign1.
- ON: restoring division over a 65-bit working register {partial remainder 33b, dividend 32b}, initialised to {33'b0, |dividend|}. Each cycle: shift left 1; subtract the zero-extended divisor from bits [64:32]; if the difference is non-negative, keep it and set bit 0 = 1, else restore and set bit 0 = 0. A 6-bit counter runs 0..31; after iteration 31, go END.
- END: apply sign fix-up (two's-complement negate quotient and/or remainder per flags); drive `result`={rem, quot} and `ready`=1. Stay in END while `start`=1; when `start`=0, go IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient wraps to 0x80000000, remainder 0. No exception.
- `annul`=1 in any state: next state IDLE, `ready`=0, `result`=0. Overrides `start` in the same cycle.
- Operands are sampled only in IDLE; changes during ON/END are ignored.

## Timing
- Reset values: state IDLE, `ready`=0, `result`=64'h0, counter 0. A mid-operation reset aborts with no result.
- `start` high at edge N (IDLE) -> ON for edges N+1..N+32 -> END after edge N+33. `ready`=1 from edge N+33 (registered) and held while `start`=1.
- `ready` and `result` are registered outputs with no combinational path from inputs.
- `start` dropping at edge M while in END -> `ready`=0 after edge M+1 (IDLE).
- `start` deasserted during ON: the operation completes and passes through END for at least one cycle, then returns to IDLE.
- Back-to-back: a new `start` is accepted only in IDLE, so consecutive divides have a minimum 1-cycle IDLE gap.

## Configuration
- `DIV_ZERO_FAST_EN` defined: divisor == 0 in IDLE -> BYZERO (one cycle) -> END with `result`=64'h0; `ready` rises 2 cycles after `start`.
- Undefined: no BYZERO state. Divide-by-zero runs the full 32 iterations and produces the algorithm's natural output after sign fix-up. For DIVU the result is quotient 0xFFFFFFFF with remainder = dividend; the result is architecturally UNPREDICTABLE. Latency is identical to the nonzero case.

## Test plan
- DIVU 7 / 2, `start` held -> `ready` rises after edge 33, `result`=64'h00000001_00000003; drop `start` -> `ready`=0 one cycle later.
- DIV 0xFFFFFFF9 (-7) / 2 -> `result`=64'hFFFFFFFF_FFFFFFFD. DIV 7 / 0xFFFFFFFE -> 64'h00000001_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000. DIVU 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF.
- Divisor 0: with `DIV_ZERO_FAST_EN`, `ready` rises after 2 edges with `result`=0. Without it, DIVU 5/0 gives `ready` after 33 edges with 64'h00000005_FFFFFFFF.
- Assert `annul` at iteration 10, then `rst` at iteration 20 of a second divide -> IDLE next edge each time, `ready`=0, `result`=0. A fresh `start` then completes correctly.
- Change `opdata1`/`opdata2` every cycle during ON -> result matches the operands sampled at `start`.
